spu_sm_norm: RTL and testbench

- Softmax normalisation stage, directly downstream of the SPU softmax sum accumulator.
- Captures the final 20-bit exponent sum and computes a fixed-point reciprocal with a sequential restoring divider.
- Then streams 4-lane 8-bit exponent vectors and emits the normalised Q0.8 probabilities p_i = x_i / sum.
- Output handshake is valid/ready, with one registered output stage.

---
 rtl/spu_sm_norm.sv | 179 +++++++++++++++++
 tb/tb_spu_sm_norm.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spu_sm_norm.sv
// Softmax normalisation stage: captures the row's exponent sum, forms a fixed-point
// reciprocal with a restoring divider, then scales 4-lane exponent vectors to Q0.8.
module spu_sm_norm #(
  parameter int SUM_W       = 20,
  parameter int RECIP_SHIFT = 27,
  parameter int RECIP_W     = 24
) (
  input  logic               core_clk,
  input  logic               rst_n,
  input  logic               sum_valid,
  input  logic [SUM_W-1:0]   sum_in,
  output logic               sum_ready,
  input  logic               x_valid,
  output logic               x_ready,
  input  logic [7:0]         x_0,
  input  logic [7:0]         x_1,
  input  logic [7:0]         x_2,
  input  logic [7:0]         x_3,
  input  logic               x_last,
  output logic               p_valid,
  input  logic               p_ready,
  output logic [7:0]         p_0,
  output logic [7:0]         p_1,
  output logic [7:0]         p_2,
  output logic [7:0]         p_3,
  output logic               p_last,
  output logic [RECIP_W-1:0] recip,
  output logic               div0
);

  localparam int Q_W    = RECIP_SHIFT + 1;
  localparam int CNT_W  = $clog2(Q_W);
  localparam int R_W    = SUM_W + 1;
  localparam int PROD_W = 8 + RECIP_W;
  localparam int P_SH   = RECIP_SHIFT - 8;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_NORM} state_t;

  state_t             state_q, state_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [SUM_W-1:0]   rem_q, rem_d;
  logic [Q_W-2:0]     quot_q, quot_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RECIP_W-1:0] recip_q, recip_d;
  logic               div0_q, div0_d;
  logic               last_seen_q, last_seen_d;
  logic               p_valid_q, p_valid_d;
  logic               p_last_q, p_last_d;
  logic [7:0]         p0_q, p1_q, p2_q, p3_q;
  logic [7:0]         p0_d, p1_d, p2_d, p3_d;

  logic [R_W-1:0]     trial;
  logic               q_bit;
  logic [Q_W-1:0]     q_full;
  logic               accept;

  function automatic logic [7:0] norm_lane(input logic [7:0] x, input logic [RECIP_W-1:0] r);
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] shifted;
    prod    = PROD_W'(x) * PROD_W'(r);
    shifted = prod >> P_SH;
    return (|shifted[PROD_W-1:8]) ? 8'hFF : shifted[7:0];
  endfunction

  // The dividend is 2^RECIP_SHIFT, so only the first bit brought down is a one.
  assign trial  = {rem_q, (cnt_q == '0)};
  assign q_bit  = (trial >= R_W'(sum_q));
  assign q_full = {quot_q, q_bit};

  assign sum_ready = (state_q == S_IDLE);
  assign x_ready   = (state_q == S_NORM) && !last_seen_q && (!p_valid_q || p_ready);
  assign accept    = x_valid && x_ready;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    rem_d       = rem_q;
    quot_d      = quot_q;
    cnt_d       = cnt_q;
    recip_d     = recip_q;
    div0_d      = div0_q;
    last_seen_d = last_seen_q;
    p_valid_d   = p_valid_q;
    p_last_d    = p_last_q;
    p0_d        = p0_q;
    p1_d        = p1_q;
    p2_d        = p2_q;
    p3_d        = p3_q;

    unique case (state_q)
      S_IDLE: begin
        if (sum_valid) begin
          sum_d       = sum_in;
          div0_d      = (sum_in == '0);
          rem_d       = '0;
          quot_d      = '0;
          cnt_d       = '0;
          last_seen_d = 1'b0;
          state_d     = S_DIV;
        end
      end
      S_DIV: begin
        rem_d  = q_bit ? SUM_W'(trial - R_W'(sum_q)) : SUM_W'(trial);
        quot_d = {quot_q[Q_W-3:0], q_bit};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(Q_W - 1)) begin
          recip_d = (|q_full[Q_W-1:RECIP_W]) ? '1 : q_full[RECIP_W-1:0];
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        if (accept) begin
          p0_d        = norm_lane(x_0, recip_q);
          p1_d        = norm_lane(x_1, recip_q);
          p2_d        = norm_lane(x_2, recip_q);
          p3_d        = norm_lane(x_3, recip_q);
          p_last_d    = x_last;
          p_valid_d   = 1'b1;
          last_seen_d = x_last;
        end else if (p_ready) begin
          p_valid_d = 1'b0;
        end
        // Once x_last is in, the only pending output is the row's final vector.
        if (last_seen_q && p_valid_q && p_ready) begin
          last_seen_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the divider registers
  // are reset too, so an abort mid-division leaves no stale remainder behind.
  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sum_q       <= '0;
      rem_q       <= '0;
      quot_q      <= '0;
      cnt_q       <= '0;
      recip_q     <= '0;
      div0_q      <= 1'b0;
      last_seen_q <= 1'b0;
      p_valid_q   <= 1'b0;
      p_last_q    <= 1'b0;
      p0_q        <= '0;
      p1_q        <= '0;
      p2_q        <= '0;
      p3_q        <= '0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      rem_q       <= rem_d;
      quot_q      <= quot_d;
      cnt_q       <= cnt_d;
      recip_q     <= recip_d;
      div0_q      <= div0_d;
      last_seen_q <= last_seen_d;
      p_valid_q   <= p_valid_d;
      p_last_q    <= p_last_d;
      p0_q        <= p0_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      p3_q        <= p3_d;
    end
  end

  assign p_valid = p_valid_q;
  assign p_last  = p_last_q;
  assign p_0     = p0_q;
  assign p_1     = p1_q;
  assign p_2     = p2_q;
  assign p_3     = p3_q;
  assign recip   = recip_q;
  assign div0    = div0_q;

endmodule

// File: tb/tb_spu_sm_norm.sv
// Scoreboard bench for spu_sm_norm: directed rows with hand-computed reciprocals
// and probabilities; a negedge monitor checks every output handshake and stall.
module tb_spu_sm_norm;

  logic        core_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sum_valid = 1'b0;
  logic [19:0] sum_in = '0;
  logic        sum_ready;
  logic        x_valid = 1'b0;
  logic        x_ready;
  logic [7:0]  x_0 = '0, x_1 = '0, x_2 = '0, x_3 = '0;
  logic        x_last = 1'b0;
  logic        p_valid;
  logic        p_ready = 1'b1;
  logic [7:0]  p_0, p_1, p_2, p_3;
  logic        p_last;
  logic [23:0] recip;
  logic        div0;

  typedef struct packed {
    logic       last;
    logic [7:0] p3;
    logic [7:0] p2;
    logic [7:0] p1;
    logic [7:0] p0;
  } vec_t;

  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 core_clk = ~core_clk;

  spu_sm_norm dut (
    .core_clk (core_clk),
    .rst_n    (rst_n),
    .sum_valid(sum_valid),
    .sum_in   (sum_in),
    .sum_ready(sum_ready),
    .x_valid  (x_valid),
    .x_ready  (x_ready),
    .x_0      (x_0),
    .x_1      (x_1),
    .x_2      (x_2),
    .x_3      (x_3),
    .x_last   (x_last),
    .p_valid  (p_valid),
    .p_ready  (p_ready),
    .p_0      (p_0),
    .p_1      (p_1),
    .p_2      (p_2),
    .p_3      (p_3),
    .p_last   (p_last),
    .recip    (recip),
    .div0     (div0)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: pops on every output handshake; during a stall the output must hold.
  vec_t held;
  logic stalled = 1'b0;
  always @(negedge core_clk) begin
    vec_t act;
    act = '{last: p_last, p3: p_3, p2: p_2, p1: p_1, p0: p_0};
    if (!rst_n) begin
      stalled = 1'b0;
    end else if (p_valid && p_ready) begin
      stalled = 1'b0;
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'(act), 64'h1_0000_0000_0000);
      end else begin
        vec_t e;
        e = exp_q.pop_front();
        check("p_lanes", 64'(act[31:0]), 64'(e[31:0]));
        check("p_last", 64'(act.last), 64'(e.last));
      end
    end else if (p_valid && !p_ready) begin
      check("stall_x_ready", 64'(x_ready), 64'd0);
      if (stalled) check("stall_hold", 64'(act), 64'(held));
      held    = act;
      stalled = 1'b1;
    end else begin
      stalled = 1'b0;
    end
  end

  // Sum handshake; returns #1 after the capture edge (cycle 1).
  task automatic issue_sum(input logic [19:0] s);
    bit ok = 0;
    @(posedge core_clk); #1;
    sum_valid = 1'b1;
    sum_in    = s;
    for (int i = 0; i < 200; i++) begin
      @(negedge core_clk);
      if (sum_ready) begin ok = 1; break; end
    end
    if (!ok) check("sum_ready_timeout", 64'd0, 64'd1);
    @(posedge core_clk); #1;
    sum_valid = 1'b0;
  endtask

  task automatic start_row(input logic [19:0] s, input logic [23:0] exp_recip, input logic exp_div0);
    int n;
    issue_sum(s);
    n = 1;
    check("sum_ready_fall", 64'(sum_ready), 64'd0);
    check("div0", 64'(div0), 64'(exp_div0));
    while (!x_ready && n < 100) begin
      @(posedge core_clk); #1;
      n++;
    end
    check("norm_latency", 64'(n), 64'd29);
    check("recip", 64'(recip), 64'(exp_recip));
  endtask

  task automatic send_x(input logic [7:0] a0, a1, a2, a3, input logic last,
                        input logic [7:0] e0, e1, e2, e3);
    bit ok = 0;
    @(posedge core_clk); #1;
    x_valid = 1'b1;
    {x_3, x_2, x_1, x_0} = {a3, a2, a1, a0};
    x_last = last;
    for (int i = 0; i < 200; i++) begin
      @(negedge core_clk);
      if (x_ready) begin
        exp_q.push_back('{last: last, p3: e3, p2: e2, p1: e1, p0: e0});
        ok = 1;
        break;
      end
      @(posedge core_clk); #1;
    end
    if (!ok) check("x_ready_timeout", 64'd0, 64'd1);
    @(posedge core_clk); #1;
    x_valid = 1'b0;
    x_last  = 1'b0;
  endtask

  // Waits for the final output handshake, then requires IDLE on the next cycle.
  task automatic wait_row_end();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge core_clk);
      if (p_valid && p_ready && p_last) begin ok = 1; break; end
    end
    if (!ok) check("row_end_timeout", 64'd0, 64'd1);
    check("sum_ready_at_last_hs", 64'(sum_ready), 64'd0);
    @(negedge core_clk);
    check("idle_sum_ready", 64'(sum_ready), 64'd1);
    check("idle_x_ready", 64'(x_ready), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset then idle
    repeat (3) @(posedge core_clk);
    #1 rst_n = 1'b1;
    @(negedge core_clk);
    check("rst_p_valid", 64'(p_valid), 64'd0);
    check("rst_p_lanes", 64'({p_3, p_2, p_1, p_0}), 64'd0);
    check("rst_p_last", 64'(p_last), 64'd0);
    check("rst_recip", 64'(recip), 64'd0);
    check("rst_div0", 64'(div0), 64'd0);
    check("rst_sum_ready", 64'(sum_ready), 64'd1);
    check("rst_x_ready", 64'(x_ready), 64'd0);

    // Basic row: recip = 2^27/1024 = 131072, p = x/4
    start_row(20'd1024, 24'd131072, 1'b0);
    send_x(8'd128, 8'd0, 8'd255, 8'd64, 1'b1, 8'd32, 8'd0, 8'd63, 8'd16);
    wait_row_end();

    // Max case: floor(2^27/255) = 526344, 255*526344 >> 19 = 255
    start_row(20'd255, 24'd526344, 1'b0);
    send_x(8'd255, 8'd0, 8'd0, 8'd0, 1'b1, 8'd255, 8'd0, 8'd0, 8'd0);
    wait_row_end();

    // Saturated reciprocal: 3*16777215 >> 19 = 95
    start_row(20'd3, 24'd16777215, 1'b0);
    send_x(8'd3, 8'd0, 8'd0, 8'd0, 1'b1, 8'd95, 8'd0, 8'd0, 8'd0);
    wait_row_end();

    // Zero sum: all-ones reciprocal, 10*16777215 >> 19 = 319 -> 255
    start_row(20'd0, 24'd16777215, 1'b1);
    send_x(8'd10, 8'd0, 8'd0, 8'd0, 1'b1, 8'd255, 8'd0, 8'd0, 8'd0);
    wait_row_end();

    // Backpressure: 4 vectors, p_ready low for 5 cycles while vector 2 is held
    start_row(20'd1024, 24'd131072, 1'b0);
    send_x(8'd4, 8'd8, 8'd12, 8'd16, 1'b0, 8'd1, 8'd2, 8'd3, 8'd4);
    send_x(8'd20, 8'd40, 8'd60, 8'd80, 1'b0, 8'd5, 8'd10, 8'd15, 8'd20);
    p_ready = 1'b0;
    fork
      send_x(8'd100, 8'd200, 8'd7, 8'd255, 1'b0, 8'd25, 8'd50, 8'd1, 8'd63);
      begin
        repeat (5) @(posedge core_clk);
        #1 p_ready = 1'b1;
      end
    join
    send_x(8'd1, 8'd2, 8'd3, 8'd252, 1'b1, 8'd0, 8'd0, 8'd0, 8'd63);
    wait_row_end();

    // Abort during DIV cycle 10, then a clean row with sum 512
    issue_sum(20'd700);
    repeat (9) @(posedge core_clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_sum_ready", 64'(sum_ready), 64'd1);
    check("abort_x_ready", 64'(x_ready), 64'd0);
    check("abort_recip", 64'(recip), 64'd0);
    check("abort_p_valid", 64'(p_valid), 64'd0);
    repeat (2) @(posedge core_clk);
    #1 rst_n = 1'b1;
    start_row(20'd512, 24'd262144, 1'b0);
    for (int i = 0; i < 3; i++) begin
      sum_valid = 1'b1;
      sum_in    = 20'd5;
      @(negedge core_clk);
      check("norm_sum_ready", 64'(sum_ready), 64'd0);
      @(posedge core_clk); #1;
    end
    sum_valid = 1'b0;
    check("norm_recip_kept", 64'(recip), 64'd262144);
    send_x(8'd128, 8'd0, 8'd255, 8'd64, 1'b1, 8'd64, 8'd0, 8'd127, 8'd32);
    wait_row_end();
    check("final_recip", 64'(recip), 64'd262144);

    repeat (3) @(posedge core_clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
